rv_hazard_detection_unit: RTL and testbench

// - Base (core-agnostic) hazard detector for the RISC-V pipelines; pure combinational hazard flags plus scan debug.
// - Flags i-mem/d-mem issue and receive stalls, JALR/taken-branch and JAL redirects, and solo-instruction serialisation.
// - Feeds the per-core control, stall and bypass units; it never stalls or flushes on its own.

---
 rtl/rv_hazard_detection_unit_pkg.sv | 36 +++
 rtl/rv_hazard_detection_unit_if.sv | 72 +++++++
 rtl/rv_hazard_detection_unit.sv | 95 +++++++++
 tb/tb_rv_hazard_detection_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_hazard_detection_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rv_hazard_detection_unit_pkg
// Purpose : Shared RISC-V definitions for the hazard detection slice.
//           Holds the base RV32 major opcodes and a log2 helper.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package rv_hazard_detection_unit_pkg;

   // RV32 major opcodes (instruction bits [6:0])
   localparam logic [6:0] R_TYPE = 7'b0110011;
   localparam logic [6:0] I_TYPE = 7'b0010011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] IMM_32 = 7'b0011011;
   localparam logic [6:0] OP_32  = 7'b0111011;

   // Ceiling log2; returns 0 for inputs of 0 or 1.
   function automatic int log2(input int value);
      int v;
      int r;
      v = value - 1;
      r = 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage : rv_hazard_detection_unit_pkg
`default_nettype wire

// File: rtl/rv_hazard_detection_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : rv_hazard_detection_unit_if
// Purpose : Bundle of pipeline status inputs and hazard flag outputs of the
//           hazard detection unit.
// Modports: master - pipeline side, drives status, observes hazard flags
//           slave  - hazard detection unit, observes status, drives flags
// Revision: 1.0  initial release
// ============================================================================
interface rv_hazard_detection_unit_if #(
   parameter int ADDRESS_BITS = 32
);
   // instruction memory
   logic                    fetch_valid;
   logic                    fetch_ready;
   logic                    issue_request;
   logic [ADDRESS_BITS-1:0] issue_PC;
   logic [ADDRESS_BITS-1:0] fetch_address_in;
   // data memory
   logic                    memory_valid;
   logic                    memory_ready;
   logic                    load_memory;
   logic                    store_memory;
   logic [ADDRESS_BITS-1:0] load_address;
   logic [ADDRESS_BITS-1:0] memory_address_in;
   // control flow
   logic [6:0]              opcode_decode;
   logic [6:0]              opcode_execute;
   logic                    branch_execute;
   // serialising instructions per stage
   logic                    solo_instr_decode;
   logic                    solo_instr_execute;
   logic                    solo_instr_memory_issue;
   logic                    solo_instr_memory_receive;
   logic                    solo_instr_writeback;
   // hazard flags
   logic                    i_mem_issue_hazard;
   logic                    i_mem_recv_hazard;
   logic                    d_mem_issue_hazard;
   logic                    d_mem_recv_hazard;
   logic                    JALR_branch_hazard;
   logic                    JAL_hazard;
   logic                    solo_instr_hazard;
   // debug
   logic                    scan;

   modport master (
      output fetch_valid, fetch_ready, issue_request, issue_PC, fetch_address_in,
      output memory_valid, memory_ready, load_memory, store_memory,
      output load_address, memory_address_in,
      output opcode_decode, opcode_execute, branch_execute,
      output solo_instr_decode, solo_instr_execute, solo_instr_memory_issue,
      output solo_instr_memory_receive, solo_instr_writeback,
      output scan,
      input  i_mem_issue_hazard, i_mem_recv_hazard, d_mem_issue_hazard,
      input  d_mem_recv_hazard, JALR_branch_hazard, JAL_hazard, solo_instr_hazard
   );

   modport slave (
      input  fetch_valid, fetch_ready, issue_request, issue_PC, fetch_address_in,
      input  memory_valid, memory_ready, load_memory, store_memory,
      input  load_address, memory_address_in,
      input  opcode_decode, opcode_execute, branch_execute,
      input  solo_instr_decode, solo_instr_execute, solo_instr_memory_issue,
      input  solo_instr_memory_receive, solo_instr_writeback,
      input  scan,
      output i_mem_issue_hazard, i_mem_recv_hazard, d_mem_issue_hazard,
      output d_mem_recv_hazard, JALR_branch_hazard, JAL_hazard, solo_instr_hazard
   );

endinterface : rv_hazard_detection_unit_if
`default_nettype wire

// File: rtl/rv_hazard_detection_unit.sv
`default_nettype none
// ============================================================================
// Module  : rv_hazard_detection_unit
// Purpose : Core-agnostic hazard detector. Raises purely combinational flags
//           for i-mem / d-mem issue and receive stalls, JALR / taken-branch
//           and JAL redirects, and solo-instruction serialisation. It never
//           stalls or flushes by itself; downstream control resolves priority.
// Ports   : clock - single clock, all state on posedge
//           reset - asynchronous, active-low
//           hdu   - rv_hazard_detection_unit_if.slave (status in, flags out)
// Config  : HDU_SCAN_EN - when defined, a free-running cycle counter and a
//           per-cycle $display of all inputs and flags are included while
//           scan is high inside [SCAN_CYCLES_MIN, SCAN_CYCLES_MAX]. When
//           undefined, scan is ignored and the hazard logic is unchanged.
// Revision: 1.0  initial release
// ============================================================================
module rv_hazard_detection_unit
   import rv_hazard_detection_unit_pkg::*;
#(
   parameter int CORE            = 0,
   parameter int ADDRESS_BITS    = 32,
   parameter int SCAN_CYCLES_MIN = 0,
   parameter int SCAN_CYCLES_MAX = 1000
) (
   input wire logic                     clock,
   input wire logic                     reset,
   rv_hazard_detection_unit_if.slave    hdu
);

   logic w_fetch_addr_mismatch;
   logic w_load_addr_mismatch;
   logic w_older_solo_in_flight;

   // Full-width equality; responses must match the exact outstanding address.
   assign w_fetch_addr_mismatch  = (hdu.issue_PC != hdu.fetch_address_in);
   assign w_load_addr_mismatch   = (hdu.load_address != hdu.memory_address_in);
   assign w_older_solo_in_flight = hdu.solo_instr_execute      |
                                   hdu.solo_instr_memory_issue |
                                   hdu.solo_instr_memory_receive |
                                   hdu.solo_instr_writeback;

   // i-mem cannot take a request and nothing is already outstanding.
   assign hdu.i_mem_issue_hazard = ~hdu.fetch_ready & ~hdu.issue_request;
   // Outstanding fetch whose response is absent or belongs to another PC.
   assign hdu.i_mem_recv_hazard  = hdu.issue_request &
                                   (~hdu.fetch_valid | w_fetch_addr_mismatch);
   assign hdu.d_mem_issue_hazard = ~hdu.memory_ready;
   assign hdu.d_mem_recv_hazard  = hdu.load_memory &
                                   (~hdu.memory_valid | w_load_addr_mismatch);
   // JALR always redirects in execute; a branch only when resolved taken.
   assign hdu.JALR_branch_hazard = (hdu.opcode_execute == JALR) |
                                   ((hdu.opcode_execute == BRANCH) & hdu.branch_execute);
   assign hdu.JAL_hazard         = (hdu.opcode_decode == JAL);
   // A solo instruction in decode waits for any older solo one to drain.
   assign hdu.solo_instr_hazard  = hdu.solo_instr_decode & w_older_solo_in_flight;

`ifdef HDU_SCAN_EN
   logic [31:0] r_cycles;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cycles <= 32'd0;
      end else begin
         r_cycles <= r_cycles + 32'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (hdu.scan &&
          (r_cycles >= 32'(SCAN_CYCLES_MIN)) &&
          (r_cycles <= 32'(SCAN_CYCLES_MAX))) begin
         $display("------ Core %0d Hazard Detection Unit - Cycle %0d ------", CORE, r_cycles);
         $display("fetch_valid %b fetch_ready %b issue_request %b issue_PC %h fetch_address_in %h",
                  hdu.fetch_valid, hdu.fetch_ready, hdu.issue_request, hdu.issue_PC,
                  hdu.fetch_address_in);
         $display("memory_valid %b memory_ready %b load_memory %b store_memory %b load_address %h memory_address_in %h",
                  hdu.memory_valid, hdu.memory_ready, hdu.load_memory, hdu.store_memory,
                  hdu.load_address, hdu.memory_address_in);
         $display("opcode_decode %b opcode_execute %b branch_execute %b",
                  hdu.opcode_decode, hdu.opcode_execute, hdu.branch_execute);
         $display("solo_instr dec %b exe %b mem_iss %b mem_rcv %b wb %b",
                  hdu.solo_instr_decode, hdu.solo_instr_execute, hdu.solo_instr_memory_issue,
                  hdu.solo_instr_memory_receive, hdu.solo_instr_writeback);
         $display("i_mem_issue %b i_mem_recv %b d_mem_issue %b d_mem_recv %b JALR_branch %b JAL %b solo %b",
                  hdu.i_mem_issue_hazard, hdu.i_mem_recv_hazard, hdu.d_mem_issue_hazard,
                  hdu.d_mem_recv_hazard, hdu.JALR_branch_hazard, hdu.JAL_hazard,
                  hdu.solo_instr_hazard);
      end
   end
`else
   // Debug scan compiled out: no cycle counter, scan and store_memory unobserved.
`endif

endmodule : rv_hazard_detection_unit
`default_nettype wire

// File: tb/tb_rv_hazard_detection_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_rv_hazard_detection_unit
// Purpose : Self-checking bench for rv_hazard_detection_unit. Directed cases
//           for each hazard rule followed by random status patterns compared
//           against a behavioural reference model.
// Revision: 1.0  initial release
// ============================================================================
module tb_rv_hazard_detection_unit;

   localparam int AB = 32;

   typedef struct {
      logic          fetch_valid, fetch_ready, issue_request;
      logic [AB-1:0] issue_pc, fetch_addr;
      logic          memory_valid, memory_ready, load_memory, store_memory;
      logic [AB-1:0] load_addr, mem_addr;
      logic [6:0]    op_dec, op_exe;
      logic          br_taken;
      logic [4:0]    solo;   // {wb, mem_rcv, mem_iss, exe, dec}
   } stim_t;

   typedef struct {
      bit i_issue, i_recv, d_issue, d_recv, jalr_br, jal, solo;
   } flags_t;

   logic clock;
   logic reset;
   int   n_tests;
   int   n_fail;

   rv_hazard_detection_unit_if #(.ADDRESS_BITS(AB)) hdu_bus ();

   rv_hazard_detection_unit #(
      .CORE            (0),
      .ADDRESS_BITS    (AB),
      .SCAN_CYCLES_MIN (0),
      .SCAN_CYCLES_MAX (1000)
   ) u_dut (
      .clock (clock),
      .reset (reset),
      .hdu   (hdu_bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] observed,
                           input logic [31:0] expected);
      n_tests = n_tests + 1;
      if (observed !== expected) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Reference: each hazard stated as the question the pipeline is asking.
   function automatic flags_t model(input stim_t s);
      flags_t f;
      int older_solo;
      f = '{default: 1'b0};
      // Can nothing be issued to i-mem this cycle and nothing is pending?
      if (s.fetch_ready == 1'b0 && s.issue_request == 1'b0) f.i_issue = 1'b1;
      // Is the pending fetch still without its own response?
      if (s.issue_request) begin
         if (!s.fetch_valid)                  f.i_recv = 1'b1;
         else if (s.issue_pc != s.fetch_addr) f.i_recv = 1'b1;
      end
      if (s.memory_ready == 1'b0) f.d_issue = 1'b1;
      if (s.load_memory) begin
         if (!s.memory_valid)              f.d_recv = 1'b1;
         else if (s.load_addr != s.mem_addr) f.d_recv = 1'b1;
      end
      case (s.op_exe)
         7'b1100111: f.jalr_br = 1'b1;
         7'b1100011: f.jalr_br = s.br_taken;
         default:    f.jalr_br = 1'b0;
      endcase
      f.jal = (s.op_dec == 7'b1101111);
      older_solo = 0;
      for (int k = 1; k < 5; k++) older_solo += int'(s.solo[k]);
      f.solo = s.solo[0] && (older_solo > 0);
      return f;
   endfunction

   task automatic drive(input stim_t s);
      hdu_bus.fetch_valid               = s.fetch_valid;
      hdu_bus.fetch_ready               = s.fetch_ready;
      hdu_bus.issue_request             = s.issue_request;
      hdu_bus.issue_PC                  = s.issue_pc;
      hdu_bus.fetch_address_in          = s.fetch_addr;
      hdu_bus.memory_valid              = s.memory_valid;
      hdu_bus.memory_ready              = s.memory_ready;
      hdu_bus.load_memory               = s.load_memory;
      hdu_bus.store_memory              = s.store_memory;
      hdu_bus.load_address              = s.load_addr;
      hdu_bus.memory_address_in         = s.mem_addr;
      hdu_bus.opcode_decode             = s.op_dec;
      hdu_bus.opcode_execute            = s.op_exe;
      hdu_bus.branch_execute            = s.br_taken;
      hdu_bus.solo_instr_decode         = s.solo[0];
      hdu_bus.solo_instr_execute        = s.solo[1];
      hdu_bus.solo_instr_memory_issue   = s.solo[2];
      hdu_bus.solo_instr_memory_receive = s.solo[3];
      hdu_bus.solo_instr_writeback      = s.solo[4];
   endtask

   // Apply away from the rising edge, then compare every flag to the model.
   task automatic apply_and_check(input stim_t s, input string tag);
      flags_t f;
      @(negedge clock);
      drive(s);
      #1;
      f = model(s);
      check_eq({tag, ".i_mem_issue"}, 32'(hdu_bus.i_mem_issue_hazard), 32'(f.i_issue));
      check_eq({tag, ".i_mem_recv"},  32'(hdu_bus.i_mem_recv_hazard),  32'(f.i_recv));
      check_eq({tag, ".d_mem_issue"}, 32'(hdu_bus.d_mem_issue_hazard), 32'(f.d_issue));
      check_eq({tag, ".d_mem_recv"},  32'(hdu_bus.d_mem_recv_hazard),  32'(f.d_recv));
      check_eq({tag, ".jalr_branch"}, 32'(hdu_bus.JALR_branch_hazard), 32'(f.jalr_br));
      check_eq({tag, ".jal"},         32'(hdu_bus.JAL_hazard),         32'(f.jal));
      check_eq({tag, ".solo"},        32'(hdu_bus.solo_instr_hazard),  32'(f.solo));
   endtask

   function automatic stim_t quiet();
      stim_t s;
      s.fetch_valid   = 1'b1; s.fetch_ready  = 1'b1; s.issue_request = 1'b0;
      s.issue_pc      = '0;   s.fetch_addr   = '0;
      s.memory_valid  = 1'b1; s.memory_ready = 1'b1; s.load_memory   = 1'b0;
      s.store_memory  = 1'b0; s.load_addr    = '0;   s.mem_addr      = '0;
      s.op_dec        = 7'b0110011; s.op_exe = 7'b0110011;
      s.br_taken      = 1'b0; s.solo = 5'b0;
      return s;
   endfunction

   function automatic logic [6:0] rand_op();
      logic [6:0] ops [4];
      ops[0] = 7'b1100111; ops[1] = 7'b1100011; ops[2] = 7'b1101111;
      ops[3] = 7'($urandom);
      return ops[$urandom_range(3, 0)];
   endfunction

   function automatic logic [AB-1:0] near(input logic [AB-1:0] a);
      if ($urandom_range(1, 0) == 0) return a;
      return a ^ (32'd1 << $urandom_range(31, 0));
   endfunction

   initial begin
      stim_t s;
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b0;
      hdu_bus.scan = 1'b1;
      drive(quiet());
      repeat (2) @(posedge clock);
      // Outputs are combinational, so they are defined even while in reset.
      apply_and_check(quiet(), "reset_idle");
      @(negedge clock);
      reset = 1'b1;

      // i-mem issue: blocked until a request is outstanding
      s = quiet(); s.fetch_ready = 1'b0;
      apply_and_check(s, "imem_issue_block");
      s.issue_request = 1'b1; s.issue_pc = 32'h100; s.fetch_addr = 32'h100;
      apply_and_check(s, "imem_issue_pending");
      // i-mem receive: address tag must match exactly
      s = quiet(); s.issue_request = 1'b1; s.issue_pc = 32'h100; s.fetch_addr = 32'h104;
      apply_and_check(s, "imem_recv_mismatch");
      s.fetch_addr = 32'h100;
      apply_and_check(s, "imem_recv_match");
      s.fetch_addr = 32'h8000_0100;
      apply_and_check(s, "imem_recv_msb");
      // d-mem receive
      s = quiet(); s.load_memory = 1'b1; s.load_addr = 32'h2000; s.mem_addr = 32'h2000;
      apply_and_check(s, "dmem_recv_match");
      s.memory_valid = 1'b0;
      apply_and_check(s, "dmem_recv_novalid");
      s = quiet(); s.memory_ready = 1'b0; s.store_memory = 1'b1;
      apply_and_check(s, "dmem_issue_block");
      // redirects
      s = quiet(); s.op_exe = 7'b1100011;
      apply_and_check(s, "branch_not_taken");
      s.br_taken = 1'b1;
      apply_and_check(s, "branch_taken");
      s.op_exe = 7'b1100111; s.br_taken = 1'b0;
      apply_and_check(s, "jalr");
      s = quiet(); s.op_dec = 7'b1101111;
      apply_and_check(s, "jal");
      // solo serialisation
      s = quiet(); s.solo = 5'b01001;
      apply_and_check(s, "solo_mem_rcv");
      s.solo = 5'b00001;
      apply_and_check(s, "solo_alone");
      s.solo = 5'b11110;
      apply_and_check(s, "solo_not_in_decode");

      // random patterns, with a reset pulse midway
      for (int i = 0; i < 300; i++) begin
         s.fetch_valid   = 1'($urandom); s.fetch_ready  = 1'($urandom);
         s.issue_request = 1'($urandom); s.issue_pc     = $urandom;
         s.fetch_addr    = near(s.issue_pc);
         s.memory_valid  = 1'($urandom); s.memory_ready = 1'($urandom);
         s.load_memory   = 1'($urandom); s.store_memory = 1'($urandom);
         s.load_addr     = $urandom;     s.mem_addr     = near(s.load_addr);
         s.op_dec        = rand_op();    s.op_exe       = rand_op();
         s.br_taken      = 1'($urandom); s.solo         = 5'($urandom);
         if (i == 150) reset = 1'b0;
         if (i == 153) reset = 1'b1;
         apply_and_check(s, (i >= 150 && i < 153) ? "rand_in_reset" : "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Bound on total run time so the bench always ends.
   initial begin
      #200000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule : tb_rv_hazard_detection_unit
`default_nettype wire
